// File: rtl/hp_monitor_seq.sv
// rtl/hp_monitor_seq.sv - Wishbone-programmable measurement sequencer for the hoggephase glitch detector.
module hp_monitor_seq #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0100,
    parameter int          SYNC_STAGES  = 2,
    parameter int          CLR_CYCLES   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    output logic        hp_vcc_o,
    output logic        hp_alarm_rst_o,
    output logic        hp_ctr_rst_o,
    input  logic        hp_alarm_latch_i,
    input  logic [7:0]  hp_alarm_ctr_i,
    output logic        busy_o,
    output logic        irq_o
);

    localparam logic [15:0] CLR_LAST = 16'(CLR_CYCLES - 1);
    localparam logic [15:0] CAP_WAIT = 16'(SYNC_STAGES + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, MEASURE, CAPTURE, DONE} state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [7:0]  settle;
    logic [15:0] window;
    logic [7:0]  thresh;
    logic        run_cont;
    logic [7:0]  cap_val;
    logic        cap_have;
    logic [3:0]  nsamp;
    logic        cap_unstable;
    logic [7:0]  last_cnt;
    logic        latch_seen;
    logic        trip;
    logic        unstable;
    logic [7:0]  run_cnt;

    logic [SYNC_STAGES-1:0] latch_q;
    logic [7:0]             ctr_q [SYNC_STAGES];
    logic                   latch_sync;
    logic [7:0]             ctr_sync;

    logic        hit, wr_ctrl, wr_cfg, wr_thresh, wr_status;
    logic        start_p, abort_p, trip_set, busy;
    logic [31:0] rdata;
    logic        unused;

    assign o_wb_stall = 1'b0;
    assign busy       = (state != IDLE);
    assign busy_o     = busy;
    assign irq_o      = trip;
    assign latch_sync = latch_q[SYNC_STAGES-1];
    assign ctr_sync   = ctr_q[SYNC_STAGES-1];
    assign unused     = ^{i_wb_addr[1:0], i_wb_data[31:24]};

    // Masking with o_wb_ack keeps a held strobe from being acked twice.
    assign hit       = i_wb_cyc && i_wb_stb && (i_wb_addr[31:4] == BASE_ADDRESS[31:4]) && !o_wb_ack;
    assign wr_ctrl   = hit && i_wb_we && (i_wb_addr[3:2] == 2'd0);
    assign wr_cfg    = hit && i_wb_we && (i_wb_addr[3:2] == 2'd1);
    assign wr_thresh = hit && i_wb_we && (i_wb_addr[3:2] == 2'd2);
    assign wr_status = hit && i_wb_we && (i_wb_addr[3:2] == 2'd3);
    assign abort_p   = wr_ctrl && i_wb_data[2];
    assign start_p   = wr_ctrl && i_wb_data[0] && !i_wb_data[2];
    assign trip_set  = (state == DONE) && !abort_p && latch_sync && (cap_val >= thresh);

    always_comb begin
        rdata = 32'd0;
        case (i_wb_addr[3:2])
            2'd1:    rdata = {8'd0, window, settle};
            2'd2:    rdata = {24'd0, thresh};
            2'd3:    rdata = {8'd0, run_cnt, 4'd0, unstable, busy, trip, latch_seen, last_cnt};
            default: rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            latch_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) ctr_q[i] <= 8'd0;
        end else begin
            latch_q  <= {latch_q[SYNC_STAGES-2:0], hp_alarm_latch_i};
            ctr_q[0] <= hp_alarm_ctr_i;
            for (int i = 1; i < SYNC_STAGES; i++) ctr_q[i] <= ctr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 16'd0;
            settle         <= 8'd0;
            window         <= 16'd0;
            thresh         <= 8'd0;
            run_cont       <= 1'b0;
            cap_val        <= 8'd0;
            cap_have       <= 1'b0;
            nsamp          <= 4'd0;
            cap_unstable   <= 1'b0;
            last_cnt       <= 8'd0;
            latch_seen     <= 1'b0;
            trip           <= 1'b0;
            unstable       <= 1'b0;
            run_cnt        <= 8'd0;
            o_wb_ack       <= 1'b0;
            o_wb_data      <= 32'd0;
            hp_vcc_o       <= 1'b0;
            hp_alarm_rst_o <= 1'b0;
            hp_ctr_rst_o   <= 1'b0;
        end else begin
            o_wb_ack  <= hit;
            o_wb_data <= (hit && !i_wb_we) ? rdata : 32'd0;
            if (wr_cfg && !busy) {window, settle} <= i_wb_data[23:0];
            if (wr_thresh && !busy) thresh <= i_wb_data[7:0];
            trip <= (trip && !(wr_status && i_wb_data[9])) || trip_set;
            if (wr_ctrl && !i_wb_data[1]) run_cont <= 1'b0;

            if (abort_p) begin
                state          <= IDLE;
                run_cont       <= 1'b0;
                hp_vcc_o       <= 1'b0;
                hp_alarm_rst_o <= 1'b0;
                hp_ctr_rst_o   <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start_p) begin
                        state          <= CLEAR;
                        cnt            <= 16'd0;
                        run_cont       <= i_wb_data[1];
                        hp_vcc_o       <= 1'b0;
                        hp_alarm_rst_o <= 1'b1;
                        hp_ctr_rst_o   <= 1'b1;
                    end
                    CLEAR: if (cnt == CLR_LAST) begin
                        cnt            <= 16'd0;
                        hp_vcc_o       <= 1'b1;
                        hp_alarm_rst_o <= 1'b0;
                        hp_ctr_rst_o   <= 1'b0;
                        state          <= (settle != 8'd0) ? SETTLE : MEASURE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                    SETTLE: if (cnt + 16'd1 == {8'd0, settle}) begin
                        cnt   <= 16'd0;
                        state <= MEASURE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                    // A window of 0 or 1 both give a single measurement cycle.
                    MEASURE: if (cnt + 16'd1 >= window) begin
                        cnt      <= 16'd0;
                        hp_vcc_o <= 1'b0;
                        cap_have <= 1'b0;
                        nsamp    <= 4'd0;
                        state    <= CAPTURE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                    // Wait for the synchronizer to flush, then accept two equal samples in a row.
                    CAPTURE: if (cnt != CAP_WAIT) begin
                        cnt <= cnt + 16'd1;
                    end else begin
                        cap_val  <= ctr_sync;
                        cap_have <= 1'b1;
                        nsamp    <= nsamp + 4'd1;
                        if (cap_have && (ctr_sync == cap_val)) begin
                            cap_unstable <= 1'b0;
                            state        <= DONE;
                        end else if (nsamp == 4'd15) begin
                            cap_unstable <= 1'b1;
                            state        <= DONE;
                        end
                    end
                    DONE: begin
                        last_cnt   <= cap_val;
                        latch_seen <= latch_sync;
                        unstable   <= cap_unstable;
                        if (run_cnt != 8'hFF) run_cnt <= run_cnt + 8'd1;
                        if (run_cont) begin
                            state          <= CLEAR;
                            cnt            <= 16'd0;
                            hp_alarm_rst_o <= 1'b1;
                            hp_ctr_rst_o   <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hp_monitor_seq.sv
// tb/tb_hp_monitor_seq.sv - Self-checking bench for hp_monitor_seq with a behavioural detector model.
module tb_hp_monitor_seq;

    localparam logic [31:0] BASE = 32'h3000_0100;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_CFG = BASE + 32'h4;
    localparam logic [31:0] A_THR = BASE + 32'h8;
    localparam logic [31:0] A_STAT = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [31:0] wb_addr = 32'd0, wb_wdata = 32'd0;
    logic        wb_ack, wb_stall;
    logic [31:0] wb_rdata;
    logic        vcc, arst, crst, busy, irq;
    logic        det_latch = 1'b0;
    logic [7:0]  det_ctr = 8'd0;
    logic        alarm_pulse = 1'b0;
    logic        toggle_en = 1'b0;

    int errors = 0;
    int checks = 0;
    bit exp_trip = 0, exp_seen = 0, exp_unst = 0;
    int exp_run = 0, exp_last = 0;

    hp_monitor_seq dut (
        .clk(clk), .reset(reset),
        .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_data(wb_wdata),
        .o_wb_ack(wb_ack), .o_wb_stall(wb_stall), .o_wb_data(wb_rdata),
        .hp_vcc_o(vcc), .hp_alarm_rst_o(arst), .hp_ctr_rst_o(crst),
        .hp_alarm_latch_i(det_latch), .hp_alarm_ctr_i(det_ctr),
        .busy_o(busy), .irq_o(irq)
    );

    always #5 clk = ~clk;

    // Detector: counts alarm pulses, latch sets on any alarm, both cleared by their resets.
    always @(posedge clk) begin
        if (crst) det_ctr <= 8'd0;
        else if (alarm_pulse) det_ctr <= det_ctr + 8'd1;
        else if (toggle_en && busy && !vcc) det_ctr <= det_ctr ^ 8'h01;
        if (arst) det_latch <= 1'b0;
        else if (alarm_pulse) det_latch <= 1'b1;
    end

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, output bit acked);
        @(negedge clk);
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_addr = a; wb_wdata = d; acked = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wb_ack) begin acked = 1; break; end
        end
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output bit acked);
        @(negedge clk);
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_addr = a; acked = 0; d = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wb_ack) begin acked = 1; d = wb_rdata; break; end
        end
        wb_cyc = 0; wb_stb = 0;
    endtask

    task automatic check_status(input string tag, input bit check_last);
        logic [31:0] s;
        bit ak;
        wb_read(A_STAT, s, ak);
        checks++;
        if (!ak) begin errors++; $display("FAIL %s status_ack got=0 want=1", tag); end
        if (check_last) begin
            checks++;
            if (s[7:0] !== 8'(exp_last)) begin errors++; $display("FAIL %s last_cnt got=%0d want=%0d", tag, s[7:0], exp_last); end
        end
        checks++;
        if (s[8] !== exp_seen) begin errors++; $display("FAIL %s latch_seen got=%0b want=%0b", tag, s[8], exp_seen); end
        checks++;
        if (s[9] !== exp_trip) begin errors++; $display("FAIL %s trip got=%0b want=%0b", tag, s[9], exp_trip); end
        checks++;
        if (s[11] !== exp_unst) begin errors++; $display("FAIL %s unstable got=%0b want=%0b", tag, s[11], exp_unst); end
        checks++;
        if (s[23:16] !== 8'(exp_run) || s[10] !== 1'b0) begin
            errors++; $display("FAIL %s run_cnt/busy got=%0d/%0b want=%0d/0", tag, s[23:16], s[10], exp_run);
        end
        checks++;
        if (irq !== exp_trip) begin errors++; $display("FAIL %s irq got=%0b want=%0b", tag, irq, exp_trip); end
    endtask

    task automatic do_run(input string tag, input int settle, input int window, input int n,
                          input int thresh, input bit toggle);
        bit ak, done;
        int vcc_cycles, rst_cycles, pulses, want_vcc;
        wb_write(A_CFG, {8'd0, 16'(window), 8'(settle)}, ak);
        wb_write(A_THR, 32'(thresh), ak);
        toggle_en = toggle;
        wb_write(A_CTRL, 32'h1, ak);
        vcc_cycles = 0; rst_cycles = 0; pulses = 0; done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            if (!busy) done = 1;
            else begin
                if (arst) rst_cycles++;
                alarm_pulse = 0;
                if (vcc) begin
                    if (vcc_cycles >= settle && pulses < n) begin alarm_pulse = 1; pulses++; end
                    vcc_cycles++;
                end
                @(negedge clk);
            end
        end
        alarm_pulse = 0;
        toggle_en = 0;
        checks++;
        if (!done) begin errors++; $display("FAIL %s run_timeout busy got=1 want=0", tag); end
        want_vcc = settle + ((window == 0) ? 1 : window);
        checks++;
        if (vcc_cycles != want_vcc) begin errors++; $display("FAIL %s vcc_cycles got=%0d want=%0d", tag, vcc_cycles, want_vcc); end
        checks++;
        if (rst_cycles != 4) begin errors++; $display("FAIL %s clear_cycles got=%0d want=4", tag, rst_cycles); end
        exp_run  = (exp_run < 255) ? exp_run + 1 : 255;
        exp_last = n;
        exp_seen = (n > 0);
        exp_unst = toggle;
        exp_trip = exp_trip || (exp_seen && n >= thresh);
        check_status(tag, !toggle);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        bit ak;
        checks++;
        if ({vcc, arst, crst, busy, irq, wb_ack, wb_stall, wb_rdata} !== 39'd0) begin
            errors++; $display("FAIL reset_outputs got=%0h want=0", {vcc, arst, crst, busy, irq, wb_ack, wb_stall, wb_rdata});
        end
        wb_read(A_STAT, d, ak);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_status got=%h want=0", d); end
        wb_read(A_CFG, d, ak);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_cfg got=%h want=0", d); end
    endtask

    task automatic test_trip_w1c;
        bit ak;
        do_run("trip", 2, 10, 5, 3, 0);
        wb_write(A_STAT, 32'h200, ak);
        exp_trip = 0;
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got=%0b want=0", irq); end
    endtask

    task automatic test_random;
        int s, w, m, n, t;
        for (int i = 0; i < 6; i++) begin
            s = $urandom_range(0, 4);
            w = $urandom_range(0, 12);
            m = (w == 0) ? 1 : w;
            n = $urandom_range(0, m);
            t = $urandom_range(0, 8);
            do_run("random", s, w, n, t, 0);
        end
    endtask

    task automatic test_continuous;
        bit ak, prev, got;
        int entries;
        wb_write(A_CFG, {8'd0, 16'd8, 8'd1}, ak);
        wb_write(A_CTRL, 32'h3, ak);
        entries = 0; prev = 0; got = 0;
        for (int c = 0; c < 5000 && !got; c++) begin
            if (arst && !prev) entries++;
            prev = arst;
            if (entries == 4 && vcc) got = 1;
            else @(negedge clk);
        end
        checks++;
        if (!got) begin errors++; $display("FAIL cont_timeout clear_entries got=%0d want=4", entries); end
        @(negedge clk);
        wb_write(A_CTRL, 32'h4, ak);
        checks++;
        if ({busy, vcc, arst, crst} !== 4'b0000) begin
            errors++; $display("FAIL abort_outputs got=%b want=0000", {busy, vcc, arst, crst});
        end
        exp_run += 3;
        exp_last = 0; exp_seen = 0; exp_unst = 0;
        check_status("continuous", 1);
    endtask

    task automatic test_cfg_busy;
        logic [31:0] d;
        bit ak, done;
        wb_write(A_CFG, {8'd0, 16'd20, 8'd3}, ak);
        wb_write(A_CTRL, 32'h1, ak);
        wb_write(A_CFG, 32'h00FF_FF77, ak);
        checks++;
        if (!ak) begin errors++; $display("FAIL cfg_busy_ack got=0 want=1"); end
        wb_read(A_CFG, d, ak);
        checks++;
        if (d !== {8'd0, 16'd20, 8'd3}) begin errors++; $display("FAIL cfg_busy_readback got=%h want=%h", d, {8'd0, 16'd20, 8'd3}); end
        done = 0;
        for (int c = 0; c < 500 && !done; c++) begin
            if (!busy) done = 1; else @(negedge clk);
        end
        checks++;
        if (!done) begin errors++; $display("FAIL cfg_busy_timeout busy got=1 want=0"); end
        exp_run++; exp_last = 0; exp_seen = 0; exp_unst = 0;
        check_status("cfg_busy", 1);
    endtask

    task automatic test_unmapped;
        logic [31:0] d;
        bit ak;
        wb_read(BASE + 32'h10, d, ak);
        checks++;
        if (ak) begin errors++; $display("FAIL unmapped_ack got=1 want=0"); end
    endtask

    task automatic test_reset_mid_run;
        logic [31:0] d;
        bit ak, got;
        wb_write(A_CFG, {8'd0, 16'd30, 8'd2}, ak);
        wb_write(A_CTRL, 32'h1, ak);
        got = 0;
        for (int c = 0; c < 50 && !got; c++) begin
            if (vcc) got = 1; else @(negedge clk);
        end
        checks++;
        if (!got) begin errors++; $display("FAIL midrun_vcc_timeout got=0 want=1"); end
        reset = 1;
        @(negedge clk);
        checks++;
        if ({vcc, arst, crst, busy, irq, wb_ack} !== 6'd0) begin
            errors++; $display("FAIL midrun_reset_outputs got=%b want=000000", {vcc, arst, crst, busy, irq, wb_ack});
        end
        reset = 0;
        wb_read(A_STAT, d, ak);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL midrun_reset_status got=%h want=0", d); end
        wb_read(A_CFG, d, ak);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL midrun_reset_cfg got=%h want=0", d); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 0;
        test_reset;
        do_run("basic", 2, 10, 0, 0, 0);
        test_trip_w1c;
        do_run("no_trip", 2, 10, 5, 6, 0);
        do_run("unstable", 1, 4, 0, 0, 1);
        do_run("min_window", 0, 0, 0, 0, 0);
        test_random;
        test_continuous;
        test_cfg_busy;
        test_unmapped;
        test_reset_mid_run;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
